// File: rtl/apx_int_acc_pkg.sv
// Shared constants for the approximate-adder result accumulator:
// FSM state encoding and default widths.
package apx_int_acc_pkg;

    localparam int DEF_DATA_PATH_BITWIDTH = 32;
    localparam int DEF_OP_BITWIDTH        = 32;
    localparam int DEF_ACC_BITWIDTH       = 48;
    localparam int DEF_CNT_BITWIDTH       = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/apx_int_acc_sat_add.sv
// Combinational accumulator adder: returns acc + operand and the carry out.
// Build option APX_ACC_SAT_EN: when defined, a carry clamps the sum to all-ones
// (and since all-ones plus anything carries again, the clamp holds for the run);
// when undefined, the sum wraps modulo 2^ACC_BW.
module apx_int_acc_sat_add
    import apx_int_acc_pkg::*;
#(
    parameter int ACC_BITWIDTH = DEF_ACC_BITWIDTH
) (
    input  logic [ACC_BITWIDTH-1:0] acc,
    input  logic [ACC_BITWIDTH-1:0] operand,
    output logic [ACC_BITWIDTH-1:0] sum,
    output logic                    carry
);

    logic [ACC_BITWIDTH:0] raw_sum;

    // Full-width add with one extra bit to expose the carry, then clamp or wrap.
    always_comb begin
        raw_sum = {1'b0, acc} + {1'b0, operand};
        carry   = raw_sum[ACC_BITWIDTH];
`ifdef APX_ACC_SAT_EN
        sum     = carry ? {ACC_BITWIDTH{1'b1}} : raw_sum[ACC_BITWIDTH-1:0];
`else
        sum     = raw_sum[ACC_BITWIDTH-1:0];
`endif
    end

endmodule

// File: rtl/apx_int_acc.sv
// Accumulates the active MSB field of a stream of adder results over a
// programmed sample count, then reports the sum with a one-cycle out_valid.
// Build option APX_ACC_SAT_EN selects saturating instead of wrapping sums
// (handled in apx_int_acc_sat_add); overflow is sticky for the run either way.
module apx_int_acc
    import apx_int_acc_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH,
    parameter int OP_BITWIDTH        = DEF_OP_BITWIDTH,
    parameter int ACC_BITWIDTH       = DEF_ACC_BITWIDTH,
    parameter int CNT_BITWIDTH       = DEF_CNT_BITWIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CNT_BITWIDTH-1:0]       num_samples,
    input  logic                          in_valid,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_data,
    output logic                          in_ready,
    output logic [ACC_BITWIDTH-1:0]       acc_out,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          overflow
);

    localparam logic [CNT_BITWIDTH-1:0] CNT_ONE = {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};

    logic [1:0]              state_reg,  state_next;
    logic [CNT_BITWIDTH-1:0] count_reg,  count_next;
    logic [CNT_BITWIDTH-1:0] target_reg, target_next;
    logic [ACC_BITWIDTH-1:0] acc_reg,    acc_next;
    logic                    ovf_reg,    ovf_next;

    logic [ACC_BITWIDTH-1:0] operand;
    logic [ACC_BITWIDTH-1:0] add_sum;
    logic                    add_carry;
    logic                    transfer;

    // Operand is the top OP_BITWIDTH bits of the data word, zero-extended to the accumulator.
    genvar gi;
    generate
        for (gi = 0; gi < ACC_BITWIDTH; gi++) begin : g_operand
            if (gi < OP_BITWIDTH) begin : g_field
                assign operand[gi] = in_data[DATA_PATH_BITWIDTH - OP_BITWIDTH + gi];
            end else begin : g_zero
                assign operand[gi] = 1'b0;
            end
        end
        // Truncated low bits of the adder word carry no information for the sum.
        if (DATA_PATH_BITWIDTH > OP_BITWIDTH) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^in_data[DATA_PATH_BITWIDTH-OP_BITWIDTH-1:0];
        end
    endgenerate

    apx_int_acc_sat_add #(
        .ACC_BITWIDTH (ACC_BITWIDTH)
    ) u_sat_add (
        .acc     (acc_reg),
        .operand (operand),
        .sum     (add_sum),
        .carry   (add_carry)
    );

    assign in_ready  = (state_reg == ST_ACCUM);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign acc_out   = acc_reg;
    assign overflow  = ovf_reg;
    assign transfer  = in_valid && (state_reg == ST_ACCUM);

    // Next-state logic: run control, sample counting and accumulation.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        target_next = target_reg;
        acc_next    = acc_reg;
        ovf_next    = ovf_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    count_next = '0;
                    if (num_samples != '0) begin
                        target_next = num_samples;
                        state_next  = ST_ACCUM;
                    end else begin
                        // Empty run: report a zero sum straight away.
                        state_next  = ST_DONE;
                    end
                end
            end
            ST_ACCUM: begin
                if (transfer) begin
                    acc_next   = add_sum;
                    ovf_next   = ovf_reg | add_carry;
                    count_next = count_reg + CNT_ONE;
                    if (count_reg == target_reg - CNT_ONE) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any run in progress immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            target_reg <= '0;
            acc_reg    <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            target_reg <= target_next;
            acc_reg    <= acc_next;
            ovf_reg    <= ovf_next;
        end
    end

endmodule

// File: tb/tb_apx_int_acc.sv
// Bench for apx_int_acc: three instances (OP=32/ACC=48, OP=16/ACC=48,
// DP=OP=ACC=8) share the data stimulus and have separate start strobes.
// Stimulus pushes expected results and status snapshots into queues; a
// negedge monitor pops and compares them against the live outputs.
module tb_apx_int_acc;

    typedef struct {
        int          dut;
        logic [47:0] acc;
        logic        ovf;
        int          due;
    } res_t;

    typedef struct {
        int          dut;
        logic        rdy;
        logic        bsy;
        logic [47:0] acc;
        logic        ovf;
    } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        start_c = 1'b0;
    logic [15:0] num_samples = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic        busy_a, busy_b, busy_c;
    logic        overflow_a, overflow_b, overflow_c;
    logic [47:0] acc_a, acc_b;
    logic [7:0]  acc_c;

    logic        ov_v  [3];
    logic        rdy_v [3];
    logic        bsy_v [3];
    logic        ovf_v [3];
    logic [47:0] acc_v [3];

    res_t        res_q [$];
    st_t         st_q  [$];
    logic [31:0] vec   [4];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic done_flag = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apx_int_acc #(
        .DATA_PATH_BITWIDTH (32), .OP_BITWIDTH (32), .ACC_BITWIDTH (48), .CNT_BITWIDTH (16)
    ) u_a (
        .clk (clk), .rst (rst), .start (start_a), .num_samples (num_samples),
        .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready_a),
        .acc_out (acc_a), .out_valid (out_valid_a), .busy (busy_a), .overflow (overflow_a)
    );

    apx_int_acc #(
        .DATA_PATH_BITWIDTH (32), .OP_BITWIDTH (16), .ACC_BITWIDTH (48), .CNT_BITWIDTH (16)
    ) u_b (
        .clk (clk), .rst (rst), .start (start_b), .num_samples (num_samples),
        .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready_b),
        .acc_out (acc_b), .out_valid (out_valid_b), .busy (busy_b), .overflow (overflow_b)
    );

    apx_int_acc #(
        .DATA_PATH_BITWIDTH (8), .OP_BITWIDTH (8), .ACC_BITWIDTH (8), .CNT_BITWIDTH (16)
    ) u_c (
        .clk (clk), .rst (rst), .start (start_c), .num_samples (num_samples),
        .in_valid (in_valid), .in_data (in_data[7:0]), .in_ready (in_ready_c),
        .acc_out (acc_c), .out_valid (out_valid_c), .busy (busy_c), .overflow (overflow_c)
    );

    assign ov_v[0]  = out_valid_a;  assign ov_v[1]  = out_valid_b;  assign ov_v[2]  = out_valid_c;
    assign rdy_v[0] = in_ready_a;   assign rdy_v[1] = in_ready_b;   assign rdy_v[2] = in_ready_c;
    assign bsy_v[0] = busy_a;       assign bsy_v[1] = busy_b;       assign bsy_v[2] = busy_c;
    assign ovf_v[0] = overflow_a;   assign ovf_v[1] = overflow_b;   assign ovf_v[2] = overflow_c;
    assign acc_v[0] = acc_a;        assign acc_v[1] = acc_b;        assign acc_v[2] = {40'd0, acc_c};

    // Monitor: the only process that compares and counts.
    always @(negedge clk) begin
        res_t e;
        st_t  s;
        for (int d = 0; d < 3; d++) begin
            if (ov_v[d]) begin
                if (res_q.size() == 0 || res_q[0].dut != d) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_valid_unexpected: dut%0d cycle %0d acc_out=%0h, required no out_valid",
                             d, cyc, acc_v[d]);
                end else begin
                    e = res_q.pop_front();
                    n_cmp++;
                    if (cyc != e.due) begin
                        n_fail++;
                        $display("FAIL out_valid_latency: dut%0d at cycle %0d, required cycle %0d", d, cyc, e.due);
                    end
                    n_cmp++;
                    if (acc_v[d] !== e.acc) begin
                        n_fail++;
                        $display("FAIL acc_out: dut%0d got %0h, required %0h", d, acc_v[d], e.acc);
                    end
                    n_cmp++;
                    if (ovf_v[d] !== e.ovf) begin
                        n_fail++;
                        $display("FAIL overflow: dut%0d got %0b, required %0b", d, ovf_v[d], e.ovf);
                    end
                    $display("result dut%0d cycle %0d acc_out=%0h overflow=%0b (expected %0h/%0b)",
                             d, cyc, acc_v[d], ovf_v[d], e.acc, e.ovf);
                end
            end
        end
        if (res_q.size() != 0 && cyc >= res_q[0].due) begin
            e = res_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL out_valid_missing: dut%0d no out_valid by cycle %0d, required at cycle %0d",
                     e.dut, cyc, e.due);
        end
        while (st_q.size() != 0) begin
            s = st_q.pop_front();
            n_cmp++;
            if (rdy_v[s.dut] !== s.rdy || bsy_v[s.dut] !== s.bsy ||
                acc_v[s.dut] !== s.acc || ovf_v[s.dut] !== s.ovf) begin
                n_fail++;
                $display("FAIL status dut%0d: in_ready=%0b busy=%0b acc_out=%0h overflow=%0b, required %0b %0b %0h %0b",
                         s.dut, rdy_v[s.dut], bsy_v[s.dut], acc_v[s.dut], ovf_v[s.dut],
                         s.rdy, s.bsy, s.acc, s.ovf);
            end else begin
                $display("status dut%0d cycle %0d: in_ready=%0b busy=%0b acc_out=%0h overflow=%0b",
                         s.dut, cyc, s.rdy, s.bsy, s.acc, s.ovf);
            end
        end
        if (done_flag) begin
            n_cmp++;
            if (res_q.size() != 0) begin
                n_fail++;
                $display("FAIL pending_results: %0d outstanding, required 0", res_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int d, input logic v);
        case (d)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic chk(input int d, input logic r, input logic b, input logic [47:0] a, input logic o);
        st_t s;
        s.dut = d; s.rdy = r; s.bsy = b; s.acc = a; s.ovf = o;
        st_q.push_back(s);
    endtask

    // Called while driving the cycle whose closing edge completes the run.
    task automatic expect_done(input int d, input logic [47:0] a, input logic o);
        res_t r;
        r.dut = d; r.acc = a; r.ovf = o; r.due = cyc + 1;
        res_q.push_back(r);
    endtask

    // One run of n samples from vec[], with 'gap' idle cycles between transfers.
    task automatic run(input int d, input int n, input int gap, input logic [47:0] ea, input logic eo);
        logic [47:0] part;
        part = '0;
        set_start(d, 1'b1);
        num_samples = n[15:0];
        if (n == 0) expect_done(d, ea, eo);
        tick();
        set_start(d, 1'b0);
        num_samples = 16'hBEEF;
        if (n == 0) chk(d, 1'b0, 1'b1, 48'd0, 1'b0);
        else        chk(d, 1'b1, 1'b1, 48'd0, 1'b0);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            if (i == n - 1) expect_done(d, ea, eo);
            tick();
            in_valid = 1'b0;
            in_data  = 32'hDEAD_BEEF;
            part = part + {16'd0, vec[i]};
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    chk(d, 1'b1, 1'b1, part, 1'b0);
                    tick();
                end
            end
        end
        tick();
        chk(d, 1'b0, 1'b0, ea, eo);
        tick();
    endtask

    initial begin
        // Reset state of all three instances
        rst = 1'b0;
        chk(0, 1'b0, 1'b0, 48'd0, 1'b0);
        chk(1, 1'b0, 1'b0, 48'd0, 1'b0);
        chk(2, 1'b0, 1'b0, 48'd0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // N=4, 1..4 back to back -> 10
        vec[0] = 32'd1; vec[1] = 32'd2; vec[2] = 32'd3; vec[3] = 32'd4;
        run(0, 4, 0, 48'd10, 1'b0);

        // OP=16: only the top half-word counts -> 3 + 1 = 4
        vec[0] = 32'h0003_FFFF; vec[1] = 32'h0001_1234;
        run(1, 2, 0, 48'd4, 1'b0);

        // N=3 with 2-cycle gaps -> 60, in_ready held high through the gaps
        vec[0] = 32'd10; vec[1] = 32'd20; vec[2] = 32'd30;
        run(0, 3, 2, 48'd60, 1'b0);

        // N=0 -> immediate zero result, previous sum cleared
        run(0, 0, 0, 48'd0, 1'b0);

        // 8-bit accumulator overflow: 0xFF + 0x02
        vec[0] = 32'h0000_00FF; vec[1] = 32'h0000_0002;
`ifdef APX_ACC_SAT_EN
        run(2, 2, 0, 48'h0FF, 1'b1);
`else
        run(2, 2, 0, 48'h001, 1'b1);
`endif
        // New run clears the sticky overflow
        vec[0] = 32'h0000_0005;
        run(2, 1, 0, 48'd5, 1'b0);

        // Start pulsed during ACCUM is ignored: N stays 3 -> 7+8+9 = 24
        set_start(0, 1'b1);
        num_samples = 16'd3;
        tick();
        set_start(0, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd7;
        set_start(0, 1'b1);
        num_samples = 16'd1;
        tick();
        set_start(0, 1'b0);
        in_data = 32'd8;
        tick();
        chk(0, 1'b1, 1'b1, 48'd15, 1'b0);
        in_data = 32'd9;
        expect_done(0, 48'd24, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk(0, 1'b0, 1'b0, 48'd24, 1'b0);
        tick();

        // Reset mid-run after two transfers: outputs clear at once, no out_valid
        set_start(0, 1'b1);
        num_samples = 16'd4;
        tick();
        set_start(0, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd100;
        tick();
        in_data  = 32'd200;
        tick();
        in_valid = 1'b0;
        chk(0, 1'b1, 1'b1, 48'd300, 1'b0);
        tick();
        #1;
        rst = 1'b0;
        chk(0, 1'b0, 1'b0, 48'd0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Next run after the abandoned one starts cleanly
        vec[0] = 32'd5; vec[1] = 32'd6;
        run(0, 2, 0, 48'd11, 1'b0);

        tick();
        tick();
        done_flag = 1'b1;
        tick();
        tick();
    end

endmodule
